// File: rtl/expr_pkg.sv
// Shared types and constants for the byte-serial expression checker.
// The SPACE character class is only produced when SPACE_SKIP_EN is defined.
package expr_pkg;

  // Recognizer states
  typedef enum logic [1:0] {
    S_OPND  = 2'd0,  // expecting an operand (digit or '(')
    S_NUM   = 2'd1,  // inside a number
    S_CLOSE = 2'd2,  // just after ')'
    S_ERR   = 2'd3   // absorbing error state
  } state_t;

  // Character classes
  typedef enum logic [2:0] {
    CL_DIGIT = 3'd0,
    CL_OP    = 3'd1,
    CL_LPAR  = 3'd2,
    CL_RPAR  = 3'd3,
    CL_SPACE = 3'd4,
    CL_OTHER = 3'd5
  } cclass_t;

  // ASCII constants
  localparam logic [7:0] CH_SPACE = 8'd32;
  localparam logic [7:0] CH_LPAR  = 8'd40;
  localparam logic [7:0] CH_RPAR  = 8'd41;
  localparam logic [7:0] CH_MUL   = 8'd42;
  localparam logic [7:0] CH_ADD   = 8'd43;
  localparam logic [7:0] CH_SUB   = 8'd45;
  localparam logic [7:0] CH_DIV   = 8'd47;
  localparam logic [7:0] CH_DIG_LO = 8'd48;
  localparam logic [7:0] CH_DIG_HI = 8'd57;

  // True for the four binary operators
  function automatic logic is_op(input logic [7:0] c);
    logic r;
    case (c)
      CH_MUL, CH_ADD, CH_SUB, CH_DIV: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

  // True for '0'..'9'
  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_DIG_LO) && (c <= CH_DIG_HI);
  endfunction

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII -> character-class encoder.
// With SPACE_SKIP_EN defined, ASCII space maps to CL_SPACE; otherwise it is CL_OTHER.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] ch,
  output cclass_t    cls
);

  // Classify the incoming character
  always_comb begin
    cls = CL_OTHER;
    if (is_digit(ch)) begin
      cls = CL_DIGIT;
    end else if (is_op(ch)) begin
      cls = CL_OP;
    end else if (ch == CH_LPAR) begin
      cls = CL_LPAR;
    end else if (ch == CH_RPAR) begin
      cls = CL_RPAR;
`ifdef SPACE_SKIP_EN
    end else if (ch == CH_SPACE) begin
      cls = CL_SPACE;
`endif
    end else begin
      cls = CL_OTHER;
    end
  end

endmodule

// File: rtl/expr_stream_checker.sv
// Byte-serial arithmetic-expression recognizer with multi-digit operands,
// parenthesis nesting, a sticky error flag and a saturating operator counter.
// Optional feature macro: SPACE_SKIP_EN (space is a no-op in non-error states).
module expr_stream_checker
  import expr_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int MAX_DEPTH  = 7,
  parameter int CNT_W      = 8,
  parameter int DEPTH_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic [CNT_W-1:0]   op_cnt
);

  localparam int DCNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [DCNT_W-1:0]  DCNT_MAX  = DCNT_W'(MAX_DIGITS);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_SAT   = {CNT_W{1'b1}};

  cclass_t            cls_s;
  logic               space_hold_s;

  state_t             state_r, state_s;
  logic [DCNT_W-1:0]  dcnt_r, dcnt_s;
  logic [DEPTH_W-1:0] depth_r, depth_s;
  logic [CNT_W-1:0]   op_cnt_r, op_cnt_s;
  logic               out_r, out_s;
  logic               err_r, err_s;

  expr_char_class u_class (
    .ch  (in),
    .cls (cls_s)
  );

`ifdef SPACE_SKIP_EN
  assign space_hold_s = (cls_s == CL_SPACE) && (state_r != S_ERR);
`else
  assign space_hold_s = 1'b0;
`endif

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r  <= S_OPND;
      dcnt_r   <= '0;
      depth_r  <= '0;
      op_cnt_r <= '0;
      out_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      dcnt_r   <= dcnt_s;
      depth_r  <= depth_s;
      op_cnt_r <= op_cnt_s;
      out_r    <= out_s;
      err_r    <= err_s;
    end
  end

  // Next-state, counter and output logic for one consumed character
  always_comb begin
    state_s  = state_r;
    dcnt_s   = dcnt_r;
    depth_s  = depth_r;
    op_cnt_s = op_cnt_r;
    out_s    = out_r;
    err_s    = err_r;

    if (in_valid && !space_hold_s) begin
      case (state_r)
        S_OPND: begin
          case (cls_s)
            CL_DIGIT: begin
              state_s = S_NUM;
              dcnt_s  = DCNT_W'(1);
            end
            CL_LPAR: begin
              if (depth_r < DEPTH_MAX) begin
                depth_s = depth_r + DEPTH_W'(1);
              end else begin
                state_s = S_ERR;
              end
            end
            default: state_s = S_ERR;
          endcase
        end
        S_NUM: begin
          case (cls_s)
            CL_DIGIT: begin
              if (dcnt_r < DCNT_MAX) begin
                dcnt_s = dcnt_r + DCNT_W'(1);
              end else begin
                state_s = S_ERR;
              end
            end
            CL_OP: begin
              state_s = S_OPND;
              dcnt_s  = '0;
              if (op_cnt_r != CNT_SAT) begin
                op_cnt_s = op_cnt_r + CNT_W'(1);
              end else begin
                op_cnt_s = op_cnt_r;
              end
            end
            CL_RPAR: begin
              if (depth_r != '0) begin
                depth_s = depth_r - DEPTH_W'(1);
                state_s = S_CLOSE;
                dcnt_s  = '0;
              end else begin
                state_s = S_ERR;
              end
            end
            default: state_s = S_ERR;
          endcase
        end
        S_CLOSE: begin
          case (cls_s)
            CL_OP: begin
              state_s = S_OPND;
              if (op_cnt_r != CNT_SAT) begin
                op_cnt_s = op_cnt_r + CNT_W'(1);
              end else begin
                op_cnt_s = op_cnt_r;
              end
            end
            CL_RPAR: begin
              if (depth_r != '0) begin
                depth_s = depth_r - DEPTH_W'(1);
              end else begin
                state_s = S_ERR;
              end
            end
            default: state_s = S_ERR;
          endcase
        end
        S_ERR: begin
          state_s = S_ERR;
        end
        default: begin
          state_s = S_ERR;
        end
      endcase

      // Depth and counter are frozen on the edge that enters the error state
      if (state_s == S_ERR) begin
        depth_s  = depth_r;
        op_cnt_s = op_cnt_r;
        dcnt_s   = dcnt_r;
      end else begin
        depth_s  = depth_s;
      end

      out_s = ((state_s == S_NUM) || (state_s == S_CLOSE)) && (depth_s == '0);
      err_s = (state_s == S_ERR);
    end else begin
      state_s = state_r;
    end
  end

  assign out    = out_r;
  assign err    = err_r;
  assign depth  = depth_r;
  assign op_cnt = op_cnt_r;

endmodule

// File: tb/tb_expr_stream_checker.sv
// Scoreboard bench for expr_stream_checker: stimulus pushes hand-computed
// expectations, a monitor pops and compares them one clk after each character.
module tb_expr_stream_checker;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in = 8'd0;
  logic       out;
  logic       err;
  logic [2:0] depth;
  logic [7:0] op_cnt;

  bit chk = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    string tag;
    bit    eo;
    bit    ee;
    int    ed;
    int    eop;
  } exp_t;

  exp_t sb[$];

  expr_stream_checker dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in       (in),
    .out      (out),
    .err      (err),
    .depth    (depth),
    .op_cnt   (op_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, req);
    end
  endtask

  // Monitor: compare DUT outputs at the negedge after each checked posedge
  initial begin
    bit c;
    exp_t e;
    forever begin
      @(posedge clk);
      c = chk;
      @(negedge clk);
      if (c) begin
        if (sb.size() == 0) begin
          cmp("scoreboard_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          cmp({e.tag, ".out"},    int'(out),    int'(e.eo));
          cmp({e.tag, ".err"},    int'(err),    int'(e.ee));
          cmp({e.tag, ".depth"},  int'(depth),  e.ed);
          cmp({e.tag, ".op_cnt"}, int'(op_cnt), e.eop);
        end
      end
    end
  end

  task automatic send(input string tag, input byte c, input bit eo, input bit ee,
                      input int ed, input int eop);
    exp_t e;
    @(negedge clk);
    #1;
    in = c;
    in_valid = 1'b1;
    chk = 1'b1;
    e.tag = tag; e.eo = eo; e.ee = ee; e.ed = ed; e.eop = eop;
    sb.push_back(e);
  endtask

  // Hold in_valid low; check outputs stay at the given values each cycle
  task automatic idle(input string tag, input int n, input bit eo, input bit ee,
                      input int ed, input int eop);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      in = 8'd49;
      in_valid = 1'b0;
      chk = 1'b1;
      e.tag = tag; e.eo = eo; e.ee = ee; e.ed = ed; e.eop = eop;
      sb.push_back(e);
    end
  endtask

  // Asynchronous clear between edges; outputs must drop immediately
  task automatic do_clr(input string tag);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    chk = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    cmp({tag, ".out"},    int'(out),    0);
    cmp({tag, ".err"},    int'(err),    0);
    cmp({tag, ".depth"},  int'(depth),  0);
    cmp({tag, ".op_cnt"}, int'(op_cnt), 0);
    @(negedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    int exp_op;
    do_clr("reset");

    // single digit
    send("t7", "7", 1'b1, 1'b0, 0, 0);
    do_clr("clr1");

    // 12+345*6
    send("a0", "1", 1'b1, 1'b0, 0, 0);
    send("a1", "2", 1'b1, 1'b0, 0, 0);
    send("a2", "+", 1'b0, 1'b0, 0, 1);
    send("a3", "3", 1'b1, 1'b0, 0, 1);
    send("a4", "4", 1'b1, 1'b0, 0, 1);
    send("a5", "5", 1'b1, 1'b0, 0, 1);
    send("a6", "*", 1'b0, 1'b0, 0, 2);
    send("a7", "6", 1'b1, 1'b0, 0, 2);
    do_clr("clr2");

    // ((3-4)*5)
    send("p0", "(", 1'b0, 1'b0, 1, 0);
    send("p1", "(", 1'b0, 1'b0, 2, 0);
    send("p2", "3", 1'b0, 1'b0, 2, 0);
    send("p3", "-", 1'b0, 1'b0, 2, 1);
    send("p4", "4", 1'b0, 1'b0, 2, 1);
    send("p5", ")", 1'b0, 1'b0, 1, 1);
    send("p6", "*", 1'b0, 1'b0, 1, 2);
    send("p7", "5", 1'b0, 1'b0, 1, 2);
    send("p8", ")", 1'b1, 1'b0, 0, 2);
    do_clr("clr3");

    // too many digits, then error is sticky
    send("d1", "1", 1'b1, 1'b0, 0, 0);
    send("d2", "2", 1'b1, 1'b0, 0, 0);
    send("d3", "3", 1'b1, 1'b0, 0, 0);
    send("d4", "4", 1'b1, 1'b0, 0, 0);
    send("d5", "5", 1'b0, 1'b1, 0, 0);
    send("d6", "+", 1'b0, 1'b1, 0, 0);
    send("d7", "1", 1'b0, 1'b1, 0, 0);
    do_clr("clr4");

    // leading ')'
    send("r0", ")", 1'b0, 1'b1, 0, 0);
    do_clr("clr5");

    // '(' after a digit
    send("q0", "8", 1'b1, 1'b0, 0, 0);
    send("q1", "(", 1'b0, 1'b1, 0, 0);
    do_clr("clr6");

    // nesting limit
    for (int i = 1; i <= 7; i++) send("n", "(", 1'b0, 1'b0, i, 0);
    send("n8", "(", 1'b0, 1'b1, 7, 0);
    do_clr("clr7");

    // unary minus and double operator
    send("u0", "-", 1'b0, 1'b1, 0, 0);
    do_clr("clr8");
    send("o0", "5", 1'b1, 1'b0, 0, 0);
    send("o1", "*", 1'b0, 1'b0, 0, 1);
    send("o2", "*", 1'b0, 1'b1, 0, 1);
    do_clr("clr9");

    // space is an ordinary illegal character in the default build
    send("s0", "1", 1'b1, 1'b0, 0, 0);
    send("s1", " ", 1'b0, 1'b1, 0, 0);
    do_clr("clr10");

    // in_valid low mid-expression holds everything
    send("h0", "9", 1'b1, 1'b0, 0, 0);
    idle("h_idle", 3, 1'b1, 1'b0, 0, 0);
    send("h1", "+", 1'b0, 1'b0, 0, 1);
    idle("h_idle2", 2, 1'b0, 1'b0, 0, 1);

    // clear mid-expression, then restart
    do_clr("clr11");
    send("m0", "(", 1'b0, 1'b0, 1, 0);
    send("m1", "1", 1'b0, 1'b0, 1, 0);
    send("m2", "+", 1'b0, 1'b0, 1, 1);
    do_clr("clr_mid");
    send("m3", "5", 1'b1, 1'b0, 0, 0);
    do_clr("clr12");

    // operator counter saturation: 256 operators, no error
    exp_op = 0;
    for (int i = 0; i < 256; i++) begin
      send("sat_d", "1", 1'b1, 1'b0, 0, exp_op);
      if (exp_op < 255) exp_op++;
      send("sat_o", "+", 1'b0, 1'b0, 0, exp_op);
    end
    send("sat_end", "2", 1'b1, 1'b0, 0, 255);

    idle("tail", 2, 1'b1, 1'b0, 0, 255);
    @(negedge clk);
    #1;
    chk = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    cmp("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got 0, expected 1");
    $fatal(1, "timeout");
  end

endmodule
